// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Each grant is bounded to MAX_BURST accepted beats and stalls on FULL.
module fifo_wr_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] DATA,
    input  logic                          FULL,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [ID_WIDTH-1:0]           GNT_ID,
    output logic [NUM_REQ-1:0]            ACK,
    output logic                          WEN,
    output logic [DATA_WIDTH-1:0]         WDATA,
    output logic                          BUSY
);
    localparam int                  CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]    LAST_BEAT   = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [ID_WIDTH-1:0] LAST_IDX    = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]  ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                state_r;
    logic [NUM_REQ-1:0]    gnt_r;
    logic [ID_WIDTH-1:0]   gnt_id_r;
    logic [ID_WIDTH-1:0]   last_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;

    logic                  pick_vld_s;
    logic [ID_WIDTH-1:0]   pick_id_s;
    logic                  accept_s;
    logic                  release_s;
    logic [NUM_REQ-1:0]    ack_s;
    logic [DATA_WIDTH-1:0] wdata_s;

    // Scans from the farthest candidate back to last+1 so the nearest requester
    // after the previous owner wins; the previous owner itself is tried last.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [ID_WIDTH-1:0] last,
        input logic [NUM_REQ-1:0]  req
    );
        logic [ID_WIDTH:0]   res;
        logic [ID_WIDTH-1:0] cand;
        int                  idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = ID_WIDTH'(idx);
            res  = req[cand] ? {1'b1, cand} : res;
        end
        return res;
    endfunction

    // Round-robin choice over the live request vector
    always_comb begin
        {pick_vld_s, pick_id_s} = rr_pick(last_r, REQ);
    end

    // Owner's write path: accept, release decision, ACK and data mux
    always_comb begin
        accept_s  = 1'b0;
        release_s = 1'b0;
        ack_s     = '0;
        wdata_s   = '0;
        if (state_r == OWN) begin
            accept_s        = REQ[gnt_id_r] & ~FULL;
            release_s       = ~REQ[gnt_id_r] | (accept_s & (cnt_r == LAST_BEAT));
            ack_s[gnt_id_r] = accept_s;
            wdata_s         = DATA[int'(gnt_id_r)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            accept_s  = 1'b0;
            release_s = 1'b0;
            ack_s     = '0;
            wdata_s   = '0;
        end
    end

    // Grant FSM: IDLE/OWN with registered grant, owner id, burst count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= IDLE;
            gnt_r    <= '0;
            gnt_id_r <= '0;
            last_r   <= LAST_IDX;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_vld_s) begin
                        state_r  <= OWN;
                        gnt_r    <= ONE_HOT_LSB << pick_id_s;
                        gnt_id_r <= pick_id_s;
                        last_r   <= pick_id_s;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                OWN: begin
                    if (release_s) begin
                        // last_r already equals the outgoing owner here
                        if (pick_vld_s) begin
                            state_r  <= OWN;
                            gnt_r    <= ONE_HOT_LSB << pick_id_s;
                            gnt_id_r <= pick_id_s;
                            last_r   <= pick_id_s;
                            cnt_r    <= '0;
                            busy_r   <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            gnt_r   <= '0;
                            cnt_r   <= '0;
                            busy_r  <= 1'b0;
                        end
                    end else if (accept_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= '0;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT    = gnt_r;
    assign GNT_ID = gnt_id_r;
    assign BUSY   = busy_r;
    assign ACK    = ack_s;
    assign WEN    = accept_s;
    assign WDATA  = wdata_s;

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Directed bench for fifo_wr_rr_arbiter (4 requesters, 32-bit data, bursts of 4).
module tb_fifo_wr_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            CLK;
    logic            RST;
    logic [N-1:0]    REQ;
    logic [N*DW-1:0] DATA;
    logic            FULL;
    logic [N-1:0]    GNT;
    logic [1:0]      GNT_ID;
    logic [N-1:0]    ACK;
    logic            WEN;
    logic [DW-1:0]   WDATA;
    logic            BUSY;

    logic [DW-1:0] dval [N];
    int n_cmp;
    int n_bad;

    fifo_wr_rr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .DATA  (DATA),
        .FULL  (FULL),
        .GNT   (GNT),
        .GNT_ID(GNT_ID),
        .ACK   (ACK),
        .WEN   (WEN),
        .WDATA (WDATA),
        .BUSY  (BUSY)
    );

    assign DATA = {dval[3], dval[2], dval[1], dval[0]};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        REQ  = 4'b0000;
        FULL = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST  = 1'b1;
        REQ  = 4'b1111;
        FULL = 1'b0;
        tick();
        #1;
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
        n_cmp++; if (GNT_ID !== 2'd0) begin n_bad++; $display("FAIL reset_gnt_id: got %0d want 0", GNT_ID); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL reset_wen: got %b want 0", WEN); end
        n_cmp++; if (ACK !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ACK); end
        n_cmp++; if (WDATA !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", WDATA); end
        tick();
        RST = 1'b0;
        REQ = 4'b0000;
        #1;
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL idle_wen: got %b want 0", WEN); end
    endtask

    task automatic test_single();
        do_reset();
        REQ = 4'b0001;
        #1;
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL single_pre_wen: got %b want 0", WEN); end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL single_gnt c%0d: got %b want 0001", k, GNT); end
            n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL single_wen c%0d: got %b want 1", k, WEN); end
            n_cmp++; if (ACK !== 4'b0001) begin n_bad++; $display("FAIL single_ack c%0d: got %b want 0001", k, ACK); end
            n_cmp++; if (WDATA !== dval[0]) begin n_bad++; $display("FAIL single_wdata c%0d: got %h want %h", k, WDATA, dval[0]); end
            n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL single_busy c%0d: got %b want 1", k, BUSY); end
        end
        tick();
        REQ = 4'b0000;
        #1;
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL single_drop_wen: got %b want 0", WEN); end
        n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL single_drop_gnt: got %b want 0001", GNT); end
        tick();
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL single_idle_gnt: got %b want 0000", GNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_round_robin();
        int id;
        logic [N-1:0] exp_gnt;
        do_reset();
        REQ = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            tick();
            id      = (k / MB) % N;
            exp_gnt = 4'b0001 << id;
            n_cmp++; if (GNT_ID !== 2'(id)) begin n_bad++; $display("FAIL rr_gnt_id c%0d: got %0d want %0d", k, GNT_ID, id); end
            n_cmp++; if (GNT !== exp_gnt) begin n_bad++; $display("FAIL rr_gnt c%0d: got %b want %b", k, GNT, exp_gnt); end
            n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL rr_wen c%0d: got %b want 1", k, WEN); end
            n_cmp++; if (ACK !== exp_gnt) begin n_bad++; $display("FAIL rr_ack c%0d: got %b want %b", k, ACK, exp_gnt); end
            n_cmp++; if (WDATA !== dval[id]) begin n_bad++; $display("FAIL rr_wdata c%0d: got %h want %h", k, WDATA, dval[id]); end
        end
    endtask

    task automatic test_full_stall();
        int beats;
        beats = 0;
        do_reset();
        REQ = 4'b0100;
        tick();
        REQ = 4'b0101;
        #1;
        if (ACK[2] === 1'b1) beats++;
        n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL stall_beat1_wen: got %b want 1", WEN); end
        n_cmp++; if (GNT_ID !== 2'd2) begin n_bad++; $display("FAIL stall_owner: got %0d want 2", GNT_ID); end
        n_cmp++; if (WDATA !== dval[2]) begin n_bad++; $display("FAIL stall_wdata: got %h want %h", WDATA, dval[2]); end
        for (int j = 0; j < 3; j++) begin
            tick();
            FULL = 1'b1;
            #1;
            n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL stall_full_wen c%0d: got %b want 0", j, WEN); end
            n_cmp++; if (GNT !== 4'b0100) begin n_bad++; $display("FAIL stall_full_gnt c%0d: got %b want 0100", j, GNT); end
            n_cmp++; if (ACK !== 4'b0000) begin n_bad++; $display("FAIL stall_full_ack c%0d: got %b want 0000", j, ACK); end
            n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL stall_full_busy c%0d: got %b want 1", j, BUSY); end
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            FULL = 1'b0;
            #1;
            if (ACK[2] === 1'b1) beats++;
            n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL stall_resume_wen c%0d: got %b want 1", j, WEN); end
            n_cmp++; if (GNT !== 4'b0100) begin n_bad++; $display("FAIL stall_resume_gnt c%0d: got %b want 0100", j, GNT); end
        end
        n_cmp++; if (beats !== 4) begin n_bad++; $display("FAIL stall_beats: got %0d want 4", beats); end
        tick();
        n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL stall_next_gnt: got %b want 0001", GNT); end
        n_cmp++; if (GNT_ID !== 2'd0) begin n_bad++; $display("FAIL stall_next_id: got %0d want 0", GNT_ID); end
        n_cmp++; if (ACK !== 4'b0001) begin n_bad++; $display("FAIL stall_next_ack: got %b want 0001", ACK); end
        n_cmp++; if (WDATA !== dval[0]) begin n_bad++; $display("FAIL stall_next_wdata: got %h want %h", WDATA, dval[0]); end
    endtask

    task automatic test_drop();
        int acks;
        acks = 0;
        do_reset();
        REQ = 4'b0010;
        tick();
        REQ = 4'b1010;
        #1;
        if (ACK[1] === 1'b1) acks++;
        n_cmp++; if (GNT !== 4'b0010) begin n_bad++; $display("FAIL drop_gnt: got %b want 0010", GNT); end
        n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL drop_b1_wen: got %b want 1", WEN); end
        tick();
        if (ACK[1] === 1'b1) acks++;
        n_cmp++; if (ACK !== 4'b0010) begin n_bad++; $display("FAIL drop_b2_ack: got %b want 0010", ACK); end
        tick();
        REQ = 4'b1000;
        #1;
        if (ACK[1] === 1'b1) acks++;
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL drop_gap_wen: got %b want 0", WEN); end
        n_cmp++; if (ACK !== 4'b0000) begin n_bad++; $display("FAIL drop_gap_ack: got %b want 0000", ACK); end
        n_cmp++; if (GNT !== 4'b0010) begin n_bad++; $display("FAIL drop_gap_gnt: got %b want 0010", GNT); end
        n_cmp++; if (acks !== 2) begin n_bad++; $display("FAIL drop_acks: got %0d want 2", acks); end
        tick();
        n_cmp++; if (GNT !== 4'b1000) begin n_bad++; $display("FAIL drop_new_gnt: got %b want 1000", GNT); end
        n_cmp++; if (GNT_ID !== 2'd3) begin n_bad++; $display("FAIL drop_new_id: got %0d want 3", GNT_ID); end
        n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL drop_new_wen: got %b want 1", WEN); end
        n_cmp++; if (WDATA !== dval[3]) begin n_bad++; $display("FAIL drop_new_wdata: got %h want %h", WDATA, dval[3]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        REQ = 4'b0100;
        tick();
        n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL arst_pre_wen: got %b want 1", WEN); end
        #1;
        RST = 1'b1;
        #1;
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL arst_gnt: got %b want 0000", GNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", BUSY); end
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL arst_wen: got %b want 0", WEN); end
        n_cmp++; if (ACK !== 4'b0000) begin n_bad++; $display("FAIL arst_ack: got %b want 0000", ACK); end
        tick();
        RST = 1'b0;
        REQ = 4'b1111;
        #1;
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL arst_idle_wen: got %b want 0", WEN); end
        tick();
        n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL arst_first_gnt: got %b want 0001", GNT); end
        n_cmp++; if (GNT_ID !== 2'd0) begin n_bad++; $display("FAIL arst_first_id: got %0d want 0", GNT_ID); end
        n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL arst_first_wen: got %b want 1", WEN); end
    endtask

    task automatic test_all_drop();
        do_reset();
        REQ = 4'b0001;
        for (int k = 0; k < MB; k++) begin
            tick();
            n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL alld_beat_wen c%0d: got %b want 1", k, WEN); end
        end
        tick();
        REQ = 4'b0000;
        #1;
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL alld_gap_wen: got %b want 0", WEN); end
        n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL alld_gap_gnt: got %b want 0001", GNT); end
        tick();
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL alld_idle_gnt: got %b want 0000", GNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL alld_idle_busy: got %b want 0", BUSY); end
        n_cmp++; if (WDATA !== 32'h0) begin n_bad++; $display("FAIL alld_idle_wdata: got %h want 0", WDATA); end
        REQ = 4'b1000;
        #1;
        n_cmp++; if (WEN !== 1'b0) begin n_bad++; $display("FAIL alld_req3_wen: got %b want 0", WEN); end
        tick();
        n_cmp++; if (GNT !== 4'b1000) begin n_bad++; $display("FAIL alld_new_gnt: got %b want 1000", GNT); end
        n_cmp++; if (GNT_ID !== 2'd3) begin n_bad++; $display("FAIL alld_new_id: got %0d want 3", GNT_ID); end
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL alld_new_busy: got %b want 1", BUSY); end
        n_cmp++; if (WEN !== 1'b1) begin n_bad++; $display("FAIL alld_new_wen: got %b want 1", WEN); end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        RST     = 1'b1;
        REQ     = 4'b0000;
        FULL    = 1'b0;
        dval[0] = 32'hA000_0A01;
        dval[1] = 32'hB111_1B12;
        dval[2] = 32'hC222_2C23;
        dval[3] = 32'hD333_3D34;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_drop();
        test_async_reset();
        test_all_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_rr_arbiter.md
# fifo_wr_rr_arbiter

Round-robin write-port arbiter placed in front of a FIFO write interface. It shares the single write port between `NUM_REQ` requesters, grants each owner a bounded burst, and honours the FIFO `FULL` back-pressure. It muxes the owner's data onto `WDATA` and drives `WEN`, which connects straight to the FIFO address controller's write enable. It runs entirely in the write-side clock domain.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16).
- `DATA_WIDTH`, 32, width of each requester's data word.
- `MAX_BURST`, 4, maximum accepted writes per grant (1..255).
- `ID_WIDTH`, $clog2(NUM_REQ), width of `GNT_ID`.

Ports:
- `CLK`  in  1  write-side clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `REQ`  in  NUM_REQ  per-requester write request; level, held while the requester has data.
- `DATA`  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `FULL`  in  1  FIFO full flag from the address controller.
- `GNT`  out  NUM_REQ  registered one-hot grant (all zero when idle).
- `GNT_ID`  out  ID_WIDTH  registered index of the current owner.
- `ACK`  out  NUM_REQ  combinational; the owner's word is accepted this cycle.
- `WEN`  out  1  combinational FIFO write enable.
- `WDATA`  out  DATA_WIDTH  the owner's data slice.
- `BUSY`  out  1  registered; 1 in state OWN.

## Operation
**States**
- IDLE: no owner.
- OWN: one requester holds the grant.

**Registered state**
- `state`, `GNT`, `GNT_ID`.
- `last` (last owner index).
- `cnt` (accepted beats in the current grant, width $clog2(MAX_BURST+1)).

**Round-robin choice (`pick`)**
- Search indices `(last+1) mod NUM_REQ` upward, wrapping, and take the first with `REQ` high.
- After reset `last = NUM_REQ-1`, so requester 0 has top priority first.

**In IDLE**
- If any `REQ` is high: load `GNT` one-hot at `pick`, `GNT_ID = pick`, `last = pick`, `cnt = 0`, go to OWN.
- Otherwise stay in IDLE.

**In OWN (owner o = GNT_ID)**
- `accept = REQ[o] & !FULL`.
- `WEN = accept`, `ACK[o] = accept`, all other `ACK` bits = 0.
- `WDATA = DATA[o]` whenever in OWN. It is don't-care when `WEN = 0`, but must still be the owner's slice.
- On accept, `cnt` increments.

**Release from OWN** happens when either condition holds:
- `REQ[o] == 0`: no write that cycle.
- Accept with `cnt == MAX_BURST-1`: the final beat is written that cycle.

On release, re-arbitrate in the same cycle using `pick` over the current `REQ`, with `last = o`:
- If any `REQ` is high, load the new owner and `cnt = 0`, then stay in OWN. The same owner is re-granted only if no other requester is requesting.
- Otherwise clear `GNT` and go to IDLE.

**FULL stall**
- While `FULL` is high, the grant and `cnt` hold and `WEN = 0`.
- There is no timeout; an owner may stall indefinitely.

**Outside OWN**
- In IDLE: `WEN = 0`, `ACK = 0`, `WDATA = 0`.

**Reset**
- Applies immediately and asynchronously: `state = IDLE`, `GNT = 0`, `GNT_ID = 0`, `BUSY = 0`, `cnt = 0`, `last = NUM_REQ-1`.
- Combinational outputs `WEN`, `ACK` and `WDATA` are therefore 0.
- A burst interrupted by reset is abandoned; no write occurs while `RST` is high.

## Timing
- Grant latency from IDLE: `REQ` is sampled high at edge N, `GNT`/`BUSY` are high after edge N. The first `WEN` can occur in that same cycle if `FULL` is low.
- Hand-over between owners has zero bubble. The last beat of owner A and the first beat of owner B are in consecutive cycles.
- Requester-drop release costs one idle write cycle: the cycle in which the owner's `REQ` is low.
- Burst length: at most `MAX_BURST` consecutive `WEN` cycles per owner while others request.
- Fairness bound: a requesting input waits at most `(NUM_REQ-1)` grants before being granted.
- Write data must be valid at `DATA[o]` in every cycle `REQ[o]` is high. Requesters advance their data on `ACK`.
- `FULL` is used as given. The arbiter adds no pipeline stage, so `FULL` must be valid in the cycle `WEN` is asserted.

## Test plan
1. Reset, then `REQ = 4'b0001` held, `FULL = 0` → `GNT = 0001` after the first edge; `WEN` high for 4 cycles; re-grant to 0 with no bubble; `ACK[0]` continuous.
2. `REQ = 4'b1111` held, `MAX_BURST = 4`, `FULL = 0` → owners 0, 1, 2, 3, 0 in turn, each with exactly 4 consecutive `WEN`; `GNT_ID` sequence 0, 1, 2, 3, 0; `WDATA` matches each owner's slice.
3. Owner 2 bursting, `FULL` high for 3 cycles after beat 1 → `WEN = 0` and `GNT` held for 3 cycles; `cnt` resumes; total 4 beats to requester 2 before release.
4. Owner 1 drops `REQ` after 2 beats while `REQ[3]` is high → 1 cycle with `WEN = 0`, then `GNT = 1000`; requester 1 receives 2 `ACK`s.
5. `RST` pulsed asynchronously mid-burst (between edges) → `GNT`, `BUSY`, `WEN` low immediately; after release with `REQ = 1111`, requester 0 is granted first.
6. All `REQ` drop on the last beat → next cycle state IDLE, `GNT = 0`, `BUSY = 0`; a new `REQ[3]` is granted after one edge.
